// File: rtl/mul8_seq_if.sv
// Request/response bundle for the sequential multiplier.
// master = execute stage, slave = multiplier.
interface mul8_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prod;
    logic        busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_prod, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_prod, busy
    );
endinterface

// File: rtl/mul8_seq.sv
// 8x8 unsigned shift-add multiplier, one time-shared adder8.
// Eight RUN iterations per request; zero operands may bypass.
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

module mul8_seq #(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    mul8_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [7:0]  mcand;
    logic [16:0] p;
    logic [2:0]  cnt;
    logic [7:0]  add_b;
    logic [7:0]  sum;
    logic        cout;
    logic        accept;
    logic        zero_op;
    logic        unused_p16;

    assign accept  = bus.in_valid && (state == IDLE);
    assign zero_op = ZERO_BYPASS &&
                     ((bus.in_a == 8'd0) || (bus.in_b == 8'd0));

    assign add_b = p[0] ? mcand : 8'h00;

    adder8 u_add (
        .a   (p[15:8]),
        .b   (add_b),
        .cin (1'b0),
        .sum (sum),
        .cout(cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (1'b1)
            (state == IDLE): begin
                if (accept) state_n = zero_op ? DONE : RUN;
            end
            (state == RUN): begin
                if (cnt == 3'd7) state_n = DONE;
            end
            (state == DONE): begin
                if (bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Shift right the 17-bit {cout, sum, low byte} each iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= 8'd0;
            p     <= 17'd0;
            cnt   <= 3'd0;
        end else if (accept) begin
            mcand <= bus.in_a;
            cnt   <= 3'd0;
            p     <= zero_op ? 17'd0 : {9'd0, bus.in_b};
        end else if (state == RUN) begin
            p   <= {1'b0, cout, sum, p[7:1]};
            cnt <= cnt + 3'd1;
        end
    end

    assign unused_p16 = p[16];

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_prod  = p[15:0];
endmodule
